// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter with per-owner bursts feeding a FIFO write port.
// One registered output stage; downstream pushback freezes everything.
module fifo_rr_arbiter #(
  parameter int N     = 4,
  parameter int DW    = 104,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    access_in,
  input  logic [N*DW-1:0] packet_in,
  output logic [N-1:0]    wait_out,
  output logic            access_out,
  output logic [DW-1:0]   packet_out,
  input  logic            wait_in
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          access_q, access_d;
  logic [DW-1:0] packet_q, packet_d;

  logic          grant;
  logic [PW-1:0] g;
  logic [7:0]    cnt_inc;

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
    if (int'(v) == N - 1) return '0;
    return v + 1'b1;
  endfunction

  // First requester at or after ptr, wrapping modulo N.
  function automatic logic [PW-1:0] rr_pick(
    input logic [N-1:0]  req,
    input logic [PW-1:0] p
  );
    logic          found;
    logic [PW-1:0] pick;
    int            idx;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(p) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    access_d = access_q;
    packet_d = packet_q;
    cnt_inc  = cnt_q + 8'd1;

    if (state_q == ARB) begin
      g     = rr_pick(access_in, ptr_q);
      grant = |access_in;
    end else begin
      g     = owner_q;
      grant = access_in[owner_q];
    end

    if (!wait_in) begin
      access_d = grant;
      if (grant) packet_d = packet_in[int'(g)*DW +: DW];
      if (state_q == ARB) begin
        if (grant) begin
          owner_d = g;
          cnt_d   = 8'd1;
          if (BURST > 1) state_d = HOLD;
          else           ptr_d   = inc_wrap(g);
        end
      end else if (grant) begin
        cnt_d = cnt_inc;
        if (cnt_inc == 8'(BURST)) begin
          state_d = ARB;
          ptr_d   = inc_wrap(owner_q);
        end
      end else begin
        // Owner dropped out: release with a bubble cycle.
        state_d = ARB;
        ptr_d   = inc_wrap(owner_q);
      end
    end

    for (int i = 0; i < N; i++) begin
      wait_out[i] = wait_in |
                    (access_in[i] & ~(grant && (g == PW'(i))));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      access_q <= 1'b0;
      packet_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      access_q <= access_d;
      packet_q <= packet_d;
    end
  end

  assign access_out = access_q;
  assign packet_out = packet_q;

endmodule
